l3_fill_controller: RTL and testbench
=====================================

# l3_fill_controller

Sequencing controller for the 8-way L3 cache, placed between L2 and the word-wide main RAM. It accepts one L2 request at a time and performs the cache lookup. On a read miss it fetches the line as four RAM word reads, writes the assembled line into the cache with a single fill, and returns the line to L2. Writes are write-through and no-write-allocate: on a hit the cache word is updated, and every write also goes to RAM.

## Interface
- `ADDR_WIDTH`, 32, byte address width
- `DATA_WIDTH`, 32, RAM/L2 word width (fixed 32)
- `LINE_SIZE`, 16, line bytes; `WORDS_PER_LINE` = 4
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `up_req_valid`  in  1  L2 request
- `up_req_ready`  out  1  high only in IDLE
- `up_we`  in  1  1 = write, 0 = read
- `up_addr`  in  ADDR_WIDTH  byte address
- `up_wdata`  in  DATA_WIDTH  write word
- `up_resp_valid`  out  1  one-cycle completion pulse
- `up_resp_hit`  out  1  request hit in L3
- `up_rdata`  out  LINE_SIZE*8  line for reads (0 for writes)
- `c_mem_valid`, `c_mem_we`  out  1  cache lookup/write strobe
- `c_mem_addr`  out  ADDR_WIDTH; `c_mem_w_data`  out  DATA_WIDTH
- `c_mem_r_data`  in  LINE_SIZE*8; `c_cache_hit`  in  1  combinational lookup result
- `c_fill_en`, `c_fill_mark_valid`  out  1  line fill strobe and validate
- `c_fill_addr`  out  ADDR_WIDTH; `c_fill_data`  out  LINE_SIZE*8
- `ram_req`, `ram_we`  out  1  RAM word request, held until ack
- `ram_addr`  out  ADDR_WIDTH; `ram_wdata`  out  DATA_WIDTH
- `ram_ack`  in  1  request done; `ram_rdata` valid on the same cycle
- `ram_rdata`  in  DATA_WIDTH

## Operation
- States: IDLE, LOOKUP, FILL_RD, FILL_WR, WR_RAM, RESP.
- IDLE: `up_req_ready`=1. On `up_req_valid`, latch `up_we`, `up_addr` and `up_wdata`, then go to LOOKUP.
- LOOKUP (exactly one cycle): drive `c_mem_valid`=1, `c_mem_we`=latched we, and the latched address/data. Sample `c_cache_hit` into the hit flag.
  - Read hit: latch `c_mem_r_data` and go to RESP.
  - Read miss: clear beat to 0 and go to FILL_RD.
  - Write, hit or miss: go to WR_RAM. The cache itself gates its word update on hit.
- FILL_RD:
  - `ram_req`=1, `ram_we`=0.
  - `ram_addr` = line base + 4*beat, where line base = address with bits [3:0] cleared.
  - On `ram_ack`, store `ram_rdata` into line bits [32*beat+31:32*beat].
  - Beat 3 acked: go to FILL_WR. Otherwise beat+1.
- FILL_WR (one cycle): `c_fill_en`=1, `c_fill_mark_valid`=1, `c_fill_addr`=line base, `c_fill_data`=assembled line. Then go to RESP.
- WR_RAM: `ram_req`=1, `ram_we`=1, `ram_addr`=latched address with bits [1:0] cleared, `ram_wdata`=latched data. On `ram_ack`, go to RESP.
- RESP (one cycle):
  - `up_resp_valid`=1 and `up_resp_hit`=hit flag.
  - `up_rdata` = line for reads, 0 for writes.
  - Then return to IDLE.
- No backpressure on the response. L2 must accept it in that cycle.
- Only one request is outstanding at a time. Requests arriving outside IDLE are not accepted.

## Timing
- Reset value of every output is 0, except `up_req_ready`=1 (IDLE). State=IDLE, beat=0, line register=0.
- Read hit: accepted at edge 0, LOOKUP in cycle 1, `up_resp_valid` in cycle 2.
- Read miss: LOOKUP, then four RAM beats, each lasting ack latency ≥1 cycle, then 1 FILL_WR cycle, then RESP. With single-cycle ack, `up_resp_valid` arrives in cycle 7.
- Write: LOOKUP, then WR_RAM until ack, then RESP. With single-cycle ack, cycle 3.
- `ram_req`, `ram_addr` and `ram_wdata` stay stable while waiting for ack. `ram_req` drops the cycle after the final ack.
- `c_mem_valid` and `c_fill_en` never assert in the same cycle.
- `up_resp_hit`=0 on every miss, including the response that follows a fill.
- Reset mid-fill: the partial line is discarded and no `c_fill_en` is issued. `ram_req` deasserts asynchronously. RAM must tolerate an abandoned request.
- `ram_ack` outside FILL_RD/WR_RAM is ignored.

## Structure
- Package `l3_ctrl_pkg`:
  - state enum `l3_ctrl_state_t`.
  - `WORDS_PER_LINE`, `LINE_BITS`, `BEAT_BITS`=2.
  - function `line_base(addr)`.
- Sub-module `l3_line_assembler`:
  - beat counter with word-insert register.
  - ports: clr, wr_en, wdata → line, last_beat.

## Test plan
- Reset, then read 0x0000_1004 (miss, RAM returns 0xA0..0xA3 for words 0..3, ack after 2 cycles):
  - RAM addresses 0x1000, 0x1004, 0x1008, 0x100C in order.
  - One `c_fill_en` with data {0xA3,0xA2,0xA1,0xA0} at 0x1000.
  - Response hit=0 with the same line.
- Repeat the read of 0x0000_1008: hit=1, response in cycle 2, no RAM request.
- Write 0xDEADBEEF to 0x0000_1008 (hit):
  - `c_mem_we`=1 in LOOKUP.
  - RAM write to 0x1008.
  - Response hit=1.
  - A subsequent read returns word 2 = 0xDEADBEEF.
- Write to 0x0002_0000 (miss): RAM write only, no `c_fill_en`, hit=0.
- Assert `rst_n`=0 during beat 2 of a fill:
  - all outputs reset immediately and no fill occurs.
  - the next read of the same line refetches all 4 beats.
- Hold `up_req_valid` through a miss: `up_req_ready`=0 until IDLE, and exactly one request is accepted per response.

Source files
------------

// File: rtl/l3_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : l3_ctrl_pkg
// Description : Shared types, sizes and helpers for the L3 fill controller.
//               Provides the controller state encoding, line geometry
//               constants and the line-base address helper.
// Revision    : 1.0 - initial release
// ============================================================================
package l3_ctrl_pkg;

    localparam int L3_ADDR_WIDTH     = 32;
    localparam int WORD_BITS         = 32;
    localparam int WORDS_PER_LINE    = 4;
    localparam int LINE_BITS         = WORDS_PER_LINE * WORD_BITS;
    localparam int BEAT_BITS         = 2;
    localparam int LINE_OFFSET_BITS  = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOOKUP  = 3'd1,
        ST_FILL_RD = 3'd2,
        ST_FILL_WR = 3'd3,
        ST_WR_RAM  = 3'd4,
        ST_RESP    = 3'd5
    } l3_ctrl_state_t;

    // Byte address of the first byte of the line containing addr.
    function automatic logic [L3_ADDR_WIDTH-1:0] line_base(
        input logic [L3_ADDR_WIDTH-1:0] addr
    );
        return {addr[L3_ADDR_WIDTH-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/l3_line_assembler.sv
`default_nettype none
// ============================================================================
// Module      : l3_line_assembler
// Description : Collects RAM words into one cache line. A beat counter
//               selects the word slot written on each wr_en; clr restarts
//               assembly from word 0 with an empty line.
// Ports       : clk, rst_n     - clock, async active-low reset
//               clr            - restart assembly (beat 0, line cleared)
//               wr_en, wdata   - store wdata into the current word slot
//               beat           - index of the word slot to be written next
//               line           - assembled line, word 0 in the low bits
//               last_beat      - current slot is the final word of the line
// Revision    : 1.0 - initial release
// ============================================================================
module l3_line_assembler
    import l3_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 wr_en,
    input  logic [WORD_BITS-1:0] wdata,
    output logic [BEAT_BITS-1:0] beat,
    output logic [LINE_BITS-1:0] line,
    output logic                 last_beat
);

    logic [BEAT_BITS-1:0] r_beat;
    logic [LINE_BITS-1:0] r_line;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat <= '0;
            r_line <= '0;
        end else if (clr) begin
            r_beat <= '0;
            r_line <= '0;
        end else if (wr_en) begin
            r_line[WORD_BITS*r_beat +: WORD_BITS] <= wdata;
            r_beat <= r_beat + 1'b1;
        end
    end

    assign beat      = r_beat;
    assign line      = r_line;
    assign last_beat = (r_beat == BEAT_BITS'(WORDS_PER_LINE - 1));

endmodule
`default_nettype wire

// File: rtl/l3_fill_controller.sv
`default_nettype none
// ============================================================================
// Module      : l3_fill_controller
// Description : Sequencer between L2 and word-wide main RAM for the L3 cache.
//               One request at a time: cache lookup, line fill on read miss
//               (four RAM word reads, one cache fill), write-through with
//               no write allocate.
// Ports       : up_*    - L2 request/response
//               c_mem_* - cache lookup / word write, c_cache_hit result
//               c_fill_*- cache line fill
//               ram_*   - main RAM word request, held until ram_ack
// Revision    : 1.0 - initial release
// ============================================================================
module l3_fill_controller
    import l3_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = L3_ADDR_WIDTH,
    parameter int DATA_WIDTH = WORD_BITS,
    parameter int LINE_SIZE  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   up_req_valid,
    output logic                   up_req_ready,
    input  logic                   up_we,
    input  logic [ADDR_WIDTH-1:0]  up_addr,
    input  logic [DATA_WIDTH-1:0]  up_wdata,
    output logic                   up_resp_valid,
    output logic                   up_resp_hit,
    output logic [LINE_SIZE*8-1:0] up_rdata,
    output logic                   c_mem_valid,
    output logic                   c_mem_we,
    output logic [ADDR_WIDTH-1:0]  c_mem_addr,
    output logic [DATA_WIDTH-1:0]  c_mem_w_data,
    input  logic [LINE_SIZE*8-1:0] c_mem_r_data,
    input  logic                   c_cache_hit,
    output logic                   c_fill_en,
    output logic                   c_fill_mark_valid,
    output logic [ADDR_WIDTH-1:0]  c_fill_addr,
    output logic [LINE_SIZE*8-1:0] c_fill_data,
    output logic                   ram_req,
    output logic                   ram_we,
    output logic [ADDR_WIDTH-1:0]  ram_addr,
    output logic [DATA_WIDTH-1:0]  ram_wdata,
    input  logic                   ram_ack,
    input  logic [DATA_WIDTH-1:0]  ram_rdata
);

    l3_ctrl_state_t          r_state;
    l3_ctrl_state_t          w_state_next;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_hit;
    logic [LINE_SIZE*8-1:0]  r_rdata;

    logic                    w_asm_clr;
    logic                    w_asm_wr;
    logic [BEAT_BITS-1:0]    w_beat;
    logic [LINE_BITS-1:0]    w_asm_line;
    logic                    w_last_beat;
    logic [ADDR_WIDTH-1:0]   w_line_base;

    assign w_line_base = line_base(r_addr);

    l3_line_assembler u_line_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (w_asm_clr),
        .wr_en     (w_asm_wr),
        .wdata     (ram_rdata),
        .beat      (w_beat),
        .line      (w_asm_line),
        .last_beat (w_last_beat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Request latch, hit flag and response line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_hit   <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (r_state == ST_IDLE && up_req_valid) begin
                r_we    <= up_we;
                r_addr  <= up_addr;
                r_wdata <= up_wdata;
            end
            if (r_state == ST_LOOKUP) begin
                r_hit <= c_cache_hit;
                if (!r_we && c_cache_hit) begin
                    r_rdata <= c_mem_r_data;
                end
            end
            if (r_state == ST_FILL_WR) begin
                r_rdata <= w_asm_line;
            end
        end
    end

    // Outputs are decoded from state so every strobe is zero outside the
    // state that owns it (and therefore zero during reset).
    always_comb begin
        w_state_next      = r_state;
        up_req_ready      = 1'b0;
        up_resp_valid     = 1'b0;
        up_resp_hit       = 1'b0;
        up_rdata          = '0;
        c_mem_valid       = 1'b0;
        c_mem_we          = 1'b0;
        c_mem_addr        = '0;
        c_mem_w_data      = '0;
        c_fill_en         = 1'b0;
        c_fill_mark_valid = 1'b0;
        c_fill_addr       = '0;
        c_fill_data       = '0;
        ram_req           = 1'b0;
        ram_we            = 1'b0;
        ram_addr          = '0;
        ram_wdata         = '0;
        w_asm_clr         = 1'b0;
        w_asm_wr          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                up_req_ready = 1'b1;
                if (up_req_valid) begin
                    w_state_next = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                c_mem_valid  = 1'b1;
                c_mem_we     = r_we;
                c_mem_addr   = r_addr;
                c_mem_w_data = r_wdata;
                if (r_we) begin
                    // The cache gates its own word update on hit.
                    w_state_next = ST_WR_RAM;
                end else if (c_cache_hit) begin
                    w_state_next = ST_RESP;
                end else begin
                    w_asm_clr    = 1'b1;
                    w_state_next = ST_FILL_RD;
                end
            end
            ST_FILL_RD: begin
                ram_req  = 1'b1;
                ram_addr = {w_line_base[ADDR_WIDTH-1:LINE_OFFSET_BITS], w_beat, 2'b00};
                w_asm_wr = ram_ack;
                if (ram_ack && w_last_beat) begin
                    w_state_next = ST_FILL_WR;
                end
            end
            ST_FILL_WR: begin
                c_fill_en         = 1'b1;
                c_fill_mark_valid = 1'b1;
                c_fill_addr       = w_line_base;
                c_fill_data       = w_asm_line;
                w_state_next      = ST_RESP;
            end
            ST_WR_RAM: begin
                ram_req   = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = {r_addr[ADDR_WIDTH-1:2], 2'b00};
                ram_wdata = r_wdata;
                if (ram_ack) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                up_resp_valid = 1'b1;
                up_resp_hit   = r_hit;
                up_rdata      = r_we ? '0 : r_rdata;
                w_state_next  = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_l3_fill_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_l3_fill_controller
// Description : Directed self-checking bench for l3_fill_controller with a
//               small behavioural cache and a latency-programmable RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l3_fill_controller;

    logic         clk;
    logic         rst_n;
    logic         up_req_valid;
    logic         up_req_ready;
    logic         up_we;
    logic [31:0]  up_addr;
    logic [31:0]  up_wdata;
    logic         up_resp_valid;
    logic         up_resp_hit;
    logic [127:0] up_rdata;
    logic         c_mem_valid;
    logic         c_mem_we;
    logic [31:0]  c_mem_addr;
    logic [31:0]  c_mem_w_data;
    logic [127:0] c_mem_r_data;
    logic         c_cache_hit;
    logic         c_fill_en;
    logic         c_fill_mark_valid;
    logic [31:0]  c_fill_addr;
    logic [127:0] c_fill_data;
    logic         ram_req;
    logic         ram_we;
    logic [31:0]  ram_addr;
    logic [31:0]  ram_wdata;
    logic         ram_ack;
    logic [31:0]  ram_rdata;

    l3_fill_controller dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .up_req_valid      (up_req_valid),
        .up_req_ready      (up_req_ready),
        .up_we             (up_we),
        .up_addr           (up_addr),
        .up_wdata          (up_wdata),
        .up_resp_valid     (up_resp_valid),
        .up_resp_hit       (up_resp_hit),
        .up_rdata          (up_rdata),
        .c_mem_valid       (c_mem_valid),
        .c_mem_we          (c_mem_we),
        .c_mem_addr        (c_mem_addr),
        .c_mem_w_data      (c_mem_w_data),
        .c_mem_r_data      (c_mem_r_data),
        .c_cache_hit       (c_cache_hit),
        .c_fill_en         (c_fill_en),
        .c_fill_mark_valid (c_fill_mark_valid),
        .c_fill_addr       (c_fill_addr),
        .c_fill_data       (c_fill_data),
        .ram_req           (ram_req),
        .ram_we            (ram_we),
        .ram_addr          (ram_addr),
        .ram_wdata         (ram_wdata),
        .ram_ack           (ram_ack),
        .ram_rdata         (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural cache (4 fully associative lines) -------
    logic [31:0]  ct_tag  [4];
    logic         ct_v    [4];
    logic [127:0] ct_data [4];
    int           ct_next = 0;

    always_comb begin
        c_cache_hit  = 1'b0;
        c_mem_r_data = '0;
        for (int i = 0; i < 4; i++) begin
            if (ct_v[i] && ct_tag[i] == {c_mem_addr[31:4], 4'h0}) begin
                c_cache_hit  = 1'b1;
                c_mem_r_data = ct_data[i];
            end
        end
    end

    always @(posedge clk) begin
        if (c_fill_en && c_fill_mark_valid) begin
            ct_tag[ct_next]  <= c_fill_addr;
            ct_v[ct_next]    <= 1'b1;
            ct_data[ct_next] <= c_fill_data;
            ct_next          <= (ct_next + 1) % 4;
        end
        if (c_mem_valid && c_mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (ct_v[i] && ct_tag[i] == {c_mem_addr[31:4], 4'h0}) begin
                    ct_data[i][32*c_mem_addr[3:2] +: 32] <= c_mem_w_data;
                end
            end
        end
    end

    // ---------------- RAM model: ack after ram_lat cycles of request ------
    logic [31:0] ram_mem [logic [31:0]];
    int          ram_lat = 1;
    int          rcnt    = 0;
    logic        pend    = 1'b0;
    logic [31:0] pend_addr, pend_wd;
    int          stab_err = 0;
    logic [31:0] log_addr [$];
    logic        log_we   [$];
    logic [31:0] log_wd   [$];

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_ack   = 1'b0;
            ram_rdata = '0;
            rcnt      = 0;
            pend      = 1'b0;
        end else if (ram_req) begin
            if (pend && (ram_addr != pend_addr || ram_wdata != pend_wd)) stab_err++;
            rcnt++;
            if (rcnt >= ram_lat) begin
                ram_ack = 1'b1;
                rcnt    = 0;
                pend    = 1'b0;
                log_addr.push_back(ram_addr);
                log_we.push_back(ram_we);
                log_wd.push_back(ram_wdata);
                if (ram_we) ram_mem[ram_addr] = ram_wdata;
                else ram_rdata = ram_mem.exists(ram_addr) ? ram_mem[ram_addr] : 32'hFFFF_FFFF;
            end else begin
                ram_ack   = 1'b0;
                pend      = 1'b1;
                pend_addr = ram_addr;
                pend_wd   = ram_wdata;
            end
        end else begin
            ram_ack = 1'b0;
            rcnt    = 0;
            pend    = 1'b0;
        end
    end

    // ---------------- monitors ---------------------------------------------
    int           fill_cnt  = 0;
    int           excl_err  = 0;
    logic [31:0]  fill_addr = '0;
    logic [127:0] fill_data = '0;
    logic         last_mem_we = 1'b0;

    always @(negedge clk) begin
        if (c_mem_valid && c_fill_en) excl_err++;
        if (c_fill_en) begin
            fill_cnt++;
            fill_addr = c_fill_addr;
            fill_data = c_fill_data;
        end
        if (c_mem_valid) last_mem_we = c_mem_we;
    end

    // Issue one request from IDLE; lat is the cycle of up_resp_valid counted
    // from the accepting edge (edge 0), or -1 on timeout.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output logic hit, output logic [127:0] rd);
        int n;
        up_we = we; up_addr = addr; up_wdata = wd; up_req_valid = 1'b1;
        n = 0;
        while (!up_req_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        up_req_valid = 1'b0;
        lat = 1; hit = 1'b0; rd = '0;
        while (!up_resp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        if (!up_resp_valid) lat = -1;
        else begin hit = up_resp_hit; rd = up_rdata; end
        @(posedge clk); #1;
    endtask

    localparam logic [127:0] LINE_A  = 128'h000000A3_000000A2_000000A1_000000A0;
    localparam logic [127:0] LINE_A2 = 128'h000000A3_DEADBEEF_000000A1_000000A0;
    localparam logic [127:0] LINE_B  = 128'h000000B3_000000B2_000000B1_000000B0;

    initial begin
        int           lat, n, base, f0, accepts, busy_ready;
        logic         hit, resp;
        logic [127:0] rd;

        for (int i = 0; i < 4; i++) begin
            ct_v[i] = 1'b0; ct_tag[i] = '0; ct_data[i] = '0;
            ram_mem[32'h1000 + 4*i] = 32'hA0 + i;
            ram_mem[32'h3000 + 4*i] = 32'hB0 + i;
            ram_mem[32'h4000 + 4*i] = 32'hC0 + i;
        end
        rst_n = 1'b0; up_req_valid = 1'b0; up_we = 1'b0; up_addr = '0; up_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", up_req_ready, 1'b1);
        check_eq("rst_strobes", {up_resp_valid, c_mem_valid, c_fill_en, ram_req}, 4'b0000);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Read miss with 2-cycle RAM ack.
        ram_lat = 2;
        do_req(1'b0, 32'h0000_1004, 32'h0, lat, hit, rd);
        check_eq("miss_lat", lat, 11);
        check_eq("miss_hit", hit, 1'b0);
        check_eq("miss_rdata", rd, LINE_A);
        check_eq("miss_beats", log_addr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("miss_ram_addr%0d", i), log_addr[i], 32'h1000 + 4*i);
            check_eq($sformatf("miss_ram_we%0d", i), log_we[i], 1'b0);
        end
        check_eq("miss_fill_cnt", fill_cnt, 1);
        check_eq("miss_fill_addr", fill_addr, 32'h1000);
        check_eq("miss_fill_data", fill_data, LINE_A);

        // Read hit.
        do_req(1'b0, 32'h0000_1008, 32'h0, lat, hit, rd);
        check_eq("hit_lat", lat, 2);
        check_eq("hit_hit", hit, 1'b1);
        check_eq("hit_rdata", rd, LINE_A);
        check_eq("hit_no_ram", log_addr.size(), 4);

        // Write hit, 1-cycle ack.
        ram_lat = 1;
        do_req(1'b1, 32'h0000_1008, 32'hDEAD_BEEF, lat, hit, rd);
        check_eq("wr_lat", lat, 3);
        check_eq("wr_hit", hit, 1'b1);
        check_eq("wr_rdata", rd, 128'h0);
        check_eq("wr_lookup_we", last_mem_we, 1'b1);
        check_eq("wr_ram_n", log_addr.size(), 5);
        check_eq("wr_ram_addr", log_addr[log_addr.size()-1], 32'h1008);
        check_eq("wr_ram_we", log_we[log_we.size()-1], 1'b1);
        check_eq("wr_ram_data", log_wd[log_wd.size()-1], 32'hDEAD_BEEF);
        do_req(1'b0, 32'h0000_1000, 32'h0, lat, hit, rd);
        check_eq("rd_after_wr_hit", hit, 1'b1);
        check_eq("rd_after_wr_data", rd, LINE_A2);

        // Write miss, unaligned byte address.
        f0 = fill_cnt;
        do_req(1'b1, 32'h0002_0002, 32'h1234_5678, lat, hit, rd);
        check_eq("wmiss_lat", lat, 3);
        check_eq("wmiss_hit", hit, 1'b0);
        check_eq("wmiss_no_fill", fill_cnt, f0);
        check_eq("wmiss_ram_addr", log_addr[log_addr.size()-1], 32'h0002_0000);
        check_eq("wmiss_ram_data", log_wd[log_wd.size()-1], 32'h1234_5678);

        // Reset during beat 2 of a fill.
        ram_lat = 2;
        base = log_addr.size();
        f0 = fill_cnt;
        up_we = 1'b0; up_addr = 32'h0000_3004; up_req_valid = 1'b1;
        @(posedge clk); #1;
        up_req_valid = 1'b0;
        n = 0;
        while (log_addr.size() < base + 2 && n < 50) begin @(negedge clk); n++; end
        check_eq("rst_fill_reach_beat2", log_addr.size(), base + 2);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_ram_req", ram_req, 1'b0);
        check_eq("rst_mid_ready", up_req_ready, 1'b1);
        check_eq("rst_mid_strobes", {up_resp_valid, c_mem_valid, c_fill_en, ram_we}, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_mid_no_fill", fill_cnt, f0);
        check_eq("rst_mid_no_beat3", log_addr.size(), base + 2);
        base = log_addr.size();
        do_req(1'b0, 32'h0000_3008, 32'h0, lat, hit, rd);
        check_eq("refetch_hit", hit, 1'b0);
        check_eq("refetch_rdata", rd, LINE_B);
        check_eq("refetch_beats", log_addr.size(), base + 4);
        check_eq("refetch_first_addr", log_addr[base], 32'h3000);
        check_eq("refetch_fill_cnt", fill_cnt, f0 + 1);

        // Hold up_req_valid through a miss (1-cycle ack).
        ram_lat = 1;
        up_we = 1'b0; up_addr = 32'h0000_4000; up_req_valid = 1'b1;
        accepts = 0; busy_ready = 0; resp = 1'b0; n = 0;
        while (!resp && n < 100) begin
            @(negedge clk);
            n++;
            if (up_resp_valid) begin
                resp = 1'b1;
                up_req_valid = 1'b0;
            end else if (up_req_ready) begin
                if (accepts > 0) busy_ready++;
                if (up_req_valid) accepts++;
            end
        end
        check_eq("hold_resp_cycle", n, 8);
        check_eq("hold_accepts", accepts, 1);
        check_eq("hold_ready_busy", busy_ready, 0);
        check_eq("hold_resp_hit", up_resp_hit, 1'b0);
        @(posedge clk); #1;
        check_eq("hold_back_idle", up_req_ready, 1'b1);

        check_eq("excl_mem_fill", excl_err, 0);
        check_eq("ram_stable", stab_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
